// File: rtl/branch_lut.sv
// Writable branch-offset lookup table: self-initialises to DEFAULT_VAL after reset,
// then serves registered lookups with a bz/bnz/jump taken decision.
// Define BRANCH_LUT_BYPASS_EN for write-first forwarding on same-address collisions.
module branch_lut #(
  parameter int          ADDR_W      = 6,
  parameter int          VAL_W       = 8,
  parameter int unsigned DEFAULT_VAL = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  output logic              init_busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [VAL_W-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        br_kind,
  input  logic              zero_flag,
  output logic              rd_valid,
  output logic [VAL_W-1:0]  rd_val,
  output logic              taken
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W:0]   r_cnt;
  logic [VAL_W-1:0]  r_mem [DEPTH];
  logic              r_rd_valid, r_taken;
  logic [VAL_W-1:0]  r_rd_val;

  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [VAL_W-1:0]  w_mem_data;
  logic              w_rd_acc;
  logic [VAL_W-1:0]  w_rd_data;
  logic              w_taken;

  always_ff @(posedge CLK) begin
    if (Reset) r_state <= S_INIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mem_we    = 1'b0;
    w_mem_addr  = wr_addr;
    w_mem_data  = wr_data;
    w_rd_acc    = 1'b0;
    case (r_state)
      S_INIT: begin
        w_mem_we   = 1'b1;
        w_mem_addr = r_cnt[ADDR_W-1:0];
        w_mem_data = VAL_W'(DEFAULT_VAL);
        if (r_cnt == (ADDR_W+1)'(DEPTH-1)) w_state_nxt = S_READY;
      end
      S_READY: begin
        w_mem_we = wr_en;
        w_rd_acc = rd_en;
      end
      default: w_state_nxt = S_INIT;
    endcase
    // Reset dominates: no table write or lookup is taken on a reset edge
    if (Reset) begin
      w_mem_we = 1'b0;
      w_rd_acc = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset)                r_cnt <= '0;
    else if (r_state == S_INIT) r_cnt <= r_cnt + 1'b1;
  end

  // Table storage is deliberately not reset; the INIT walk rewrites every entry
  always_ff @(posedge CLK) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
  end

`ifdef BRANCH_LUT_BYPASS_EN
  assign w_rd_data = (wr_en && (wr_addr == rd_addr)) ? wr_data : r_mem[rd_addr];
`else
  assign w_rd_data = r_mem[rd_addr];
`endif

  always_comb begin
    w_taken = 1'b0;
    case (br_kind)
      2'b01:   w_taken = zero_flag;
      2'b10:   w_taken = ~zero_flag;
      2'b11:   w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_rd_valid <= 1'b0;
      r_rd_val   <= '0;
      r_taken    <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_val <= w_rd_data;
        r_taken  <= w_taken;
      end
    end
  end

  assign init_busy = (r_state == S_INIT);
  assign rd_valid  = r_rd_valid;
  assign rd_val    = r_rd_val;
  assign taken     = r_taken;

endmodule
